// File: rtl/issue_queue.sv
// Dual-ported issue queue between decode and dispatch.
// A circular buffer holds up to DEPTH entries. Up to two entries are written
// and up to two are issued each cycle. The two oldest entries are always
// presented to dispatch, with bit0 of each output acting as the busy flag.
module issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [106:0]             in_inst0,
  input  logic [106:0]             in_inst1,
  output logic                     iq_allin,
  input  logic [1:0]               issue_enable,
  output logic [106:0]             inst0_to_dispatch,
  output logic [106:0]             inst1_to_dispatch,
  output logic [$clog2(DEPTH):0]   iq_count,
  output logic                     iq_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Bit0 of each stored entry is replaced by the busy flag on the way out,
  // so only bits [106:1] are kept.
  logic [106:1]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [AW-1:0] w_wr_ptr1;
  logic [AW-1:0] w_rd_ptr1;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pop_req;
  logic [1:0]    w_pop_n;
  logic          w_unused_bit0;

  assign w_unused_bit0 = in_inst0[0] ^ in_inst1[0];

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);
  assign w_rd_ptr1 = r_rd_ptr + AW'(1);

  // There is always room for two entries when fewer than DEPTH-1 are held.
  assign iq_allin = (r_count <= CW'(DEPTH - 2));
  assign iq_count = r_count;
  assign iq_empty = (r_count == '0);

  // Number of entries accepted this cycle; nothing is accepted without room.
  always_comb begin
    w_push_n = 2'd0;
    if (iq_allin) begin
      case (in_valid)
        2'b01, 2'b10: w_push_n = 2'd1;
        2'b11:        w_push_n = 2'd2;
        default:      w_push_n = 2'd0;
      endcase
    end
  end

  // Number of entries issued this cycle, clamped to what is actually held.
  always_comb begin
    w_pop_req = 2'd0;
    case (issue_enable)
      2'b01:   w_pop_req = 2'd1;
      2'b10:   w_pop_req = 2'd2;
      default: w_pop_req = 2'd0;
    endcase
    w_pop_n = w_pop_req;
    if (CW'(w_pop_req) > r_count) begin
      w_pop_n = r_count[1:0];
    end
  end

  // Pointer and occupancy state; flush discards everything, including any
  // push or pop requested in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_n);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_n);
      r_count  <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

  // Entry storage, written in program order; contents need no reset because
  // the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (iq_allin && !flush) begin
      case (in_valid)
        2'b01: r_mem[r_wr_ptr] <= in_inst0[106:1];
        2'b10: r_mem[r_wr_ptr] <= in_inst1[106:1];
        2'b11: begin
          r_mem[r_wr_ptr]  <= in_inst0[106:1];
          r_mem[w_wr_ptr1] <= in_inst1[106:1];
        end
        default: ;
      endcase
    end
  end

  // Oldest two entries, zeroed when not present.
  always_comb begin
    inst0_to_dispatch = '0;
    inst1_to_dispatch = '0;
    if (r_count >= CW'(1)) begin
      inst0_to_dispatch = {r_mem[r_rd_ptr], 1'b1};
    end
    if (r_count >= CW'(2)) begin
      inst1_to_dispatch = {r_mem[w_rd_ptr1], 1'b1};
    end
  end

endmodule
